instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 29 ++
 rtl/instruction_fetch_fifo.sv | 56 +++++
 rtl/instruction_fetch.sv | 84 ++++++++
 tb/tb_instruction_fetch.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit definitions: FSM encoding, reset PC default and
// instruction constants used across the front end.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: instruction memory request/response, redirect strobe and
// the instruction stream handed to decode.
interface instruction_fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_ack_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_ack_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i, instr_ready_i
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Power-of-two circular buffer with flush and occupancy count; a push into a
// full buffer is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW:0]    FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = 1;
    localparam logic [AW:0]    CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL) || do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: credit-limited in-order requests, PC tagging of
// responses, buffered hand-off to decode, and redirect with response drain.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    logic [1:0]     outstanding;
    logic [1:0]     outstanding_nxt;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           ack_fire;
    logic           push;
    logic           pop;
    logic [31:0]    tag_pc;
    logic [63:0]    head;

    // The tag queue holds one PC per accepted request, so its occupancy is
    // the outstanding-response count.
    fetch_fifo #(.WIDTH(32), .DEPTH(2)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (ack_fire),
        .push_data (fetch_pc),
        .pop       (bus.imem_rvalid_i),
        .pop_data  (tag_pc),
        .count     (outstanding)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_i),
        .push      (push),
        .push_data ({tag_pc, bus.imem_rdata_i}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign fifo_empty      = (fifo_count == '0);
    assign bus.imem_req_o  = (state == FETCH) && (outstanding < 2'd2) &&
                             ((32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH);
    assign bus.imem_addr_o = fetch_pc;
    assign ack_fire        = bus.imem_req_o && bus.imem_ack_i;
    assign push            = bus.imem_rvalid_i && (state == FETCH) && !bus.redirect_i;
    assign pop             = !fifo_empty && bus.instr_ready_i && !bus.redirect_i;
    assign outstanding_nxt = outstanding + 2'(ack_fire) - 2'(bus.imem_rvalid_i);

    assign bus.instr_valid_o = !fifo_empty;
    assign bus.instr_pc_o    = fifo_empty ? '0 : head[63:32];
    assign bus.instr_o       = fifo_empty ? '0 : head[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            if (bus.redirect_i)  fetch_pc <= word_align(bus.redirect_pc_i);
            else if (ack_fire)   fetch_pc <= fetch_pc + INSTR_BYTES;

            // A request acked in the redirect cycle still returns data, so it
            // counts toward the drain.
            unique case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (bus.redirect_i && outstanding_nxt != 2'd0) state <= DRAIN;
                DRAIN:   if (outstanding_nxt == 2'd0) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: a memory responder and
// program-order PC model predict the instruction stream seen by decode.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] maddr;
        logic [31:0] daddr;
        logic        stale;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;

    instruction_fetch_if bus0();
    instruction_fetch_if bus1();

    instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          pop_count = 0;
    req_t        pending[$];
    exp_t        exp_q[$];
    req_t        cur;
    bit          cur_valid = 1'b0;
    logic [31:0] exp_fetch_pc = 32'h0;
    bit          mon_en = 1'b0;
    bit          after_redirect = 1'b0;
    bit          redir_req = 1'b0;
    logic [31:0] redir_target = 32'h0;
    int unsigned ack_pct = 0;
    int unsigned rv_pct  = 0;
    int unsigned rdy_pct = 0;
    bit          wrap_done = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus0.imem_ack_i    = 1'b0;
        bus0.imem_rvalid_i = 1'b0;
        bus0.imem_rdata_i  = 32'h0;
        bus0.redirect_i    = 1'b0;
        bus0.redirect_pc_i = 32'h0;
        bus0.instr_ready_i = 1'b0;
    endtask

    // One clock of stimulus: drive at negedge, observe just before posedge.
    task automatic step();
        logic        sent_redir;
        logic [31:0] sent_target;
        @(negedge clk);
        bus0.imem_ack_i = ($urandom_range(99) < ack_pct);
        cur_valid = 1'b0;
        if (pending.size() != 0 && $urandom_range(99) < rv_pct) begin
            cur = pending.pop_front();
            cur_valid = 1'b1;
        end
        bus0.imem_rvalid_i = cur_valid;
        bus0.imem_rdata_i  = cur_valid ? mem_word(cur.daddr) : $urandom();
        bus0.instr_ready_i = ($urandom_range(99) < rdy_pct);
        sent_redir  = redir_req;
        sent_target = redir_target;
        bus0.redirect_i    = sent_redir;
        bus0.redirect_pc_i = sent_redir ? sent_target : $urandom();
        redir_req = 1'b0;
        #4;
        if (after_redirect) begin
            chk("valid_after_redirect", 32'(bus0.instr_valid_o), 32'd0);
            after_redirect = 1'b0;
        end
        if (bus0.imem_req_o && bus0.imem_ack_i) begin
            chk("credit_outstanding", 32'((pending.size() + (cur_valid ? 1 : 0)) < 2), 32'd1);
            chk("fetch_addr", bus0.imem_addr_o, exp_fetch_pc);
            pending.push_back(req_t'{exp_fetch_pc, bus0.imem_addr_o, 1'b0});
            exp_fetch_pc += 32'd4;
        end
        if (sent_redir) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            cur.stale = 1'b1;
            exp_q.delete();
            exp_fetch_pc = sent_target & ~32'd3;
            after_redirect = 1'b1;
        end
        if (cur_valid && !cur.stale) exp_q.push_back(exp_t'{cur.maddr, mem_word(cur.maddr)});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && rst && bus0.instr_valid_o && bus0.instr_ready_i && !bus0.redirect_i) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h want no instruction", bus0.instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", bus0.instr_pc_o, e.pc);
                    chk("instr_word", bus0.instr_o, e.data);
                end
            end
        end
    end

    initial begin : wrap_test
        logic [31:0] wrap_exp [3];
        logic [31:0] acc_addr;
        bit          acc;
        int          nacc;
        int          npop;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        acc = 1'b0; acc_addr = 32'h0; nacc = 0; npop = 0;
        bus1.imem_ack_i    = 1'b1;
        bus1.imem_rvalid_i = 1'b0;
        bus1.imem_rdata_i  = 32'h0;
        bus1.redirect_i    = 1'b0;
        bus1.redirect_pc_i = 32'h0;
        bus1.instr_ready_i = 1'b1;
        wait (rst === 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus1.imem_rvalid_i = acc;
            bus1.imem_rdata_i  = acc_addr;
            #4;
            if (bus1.instr_valid_o && bus1.instr_ready_i) begin
                if (npop < 3) begin
                    chk("wrap_instr_pc", bus1.instr_pc_o, wrap_exp[npop]);
                    chk("wrap_instr_word", bus1.instr_o, wrap_exp[npop]);
                end
                npop++;
            end
            acc = bus1.imem_req_o && bus1.imem_ack_i;
            if (acc) begin
                if (nacc < 3) chk("wrap_addr", bus1.imem_addr_o, wrap_exp[nacc]);
                acc_addr = bus1.imem_addr_o;
                nacc++;
            end
        end
        chk("wrap_addr_count", 32'(nacc >= 3), 32'd1);
        chk("wrap_pop_count", 32'(npop >= 3), 32'd1);
        @(negedge clk);
        bus1.imem_ack_i    = 1'b0;
        bus1.imem_rvalid_i = 1'b0;
        wrap_done = 1'b1;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        int p0;
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #4;
        chk("rst_req", 32'(bus0.imem_req_o), 32'd0);
        chk("rst_valid", 32'(bus0.instr_valid_o), 32'd0);
        chk("rst_addr", bus0.imem_addr_o, 32'h0);
        chk("rst_instr", bus0.instr_o, 32'h0);
        chk("rst_instr_pc", bus0.instr_pc_o, 32'h0);
        chk("rst_addr_wrap_dut", bus1.imem_addr_o, 32'hFFFF_FFF8);

        @(negedge clk);
        rst = 1'b1;
        exp_fetch_pc = 32'h0;
        mon_en = 1'b1;

        // Back-to-back fetch with immediate responses
        ack_pct = 100; rv_pct = 100; rdy_pct = 100;
        step();
        step();
        chk("lat_valid_early", 32'(bus0.instr_valid_o), 32'd0);
        step();
        chk("lat_first_valid", 32'(bus0.instr_valid_o), 32'd1);
        chk("lat_first_pc", bus0.instr_pc_o, 32'h0);
        step();
        chk("lat_second_pc", bus0.instr_pc_o, 32'h4);
        step();
        chk("lat_third_pc", bus0.instr_pc_o, 32'h8);

        // Decode stalled: buffer fills, requests stop, then drains in order
        rdy_pct = 0;
        repeat (10) step();
        chk("stall_req_low", 32'(bus0.imem_req_o), 32'd0);
        chk("stall_valid", 32'(bus0.instr_valid_o), 32'd1);
        chk("stall_outstanding", 32'(pending.size()), 32'd0);
        ack_pct = 0; rdy_pct = 100;
        p0 = pop_count;
        repeat (5) step();
        chk("stall_drain_count", 32'(pop_count - p0), 32'd4);
        chk("stall_drained_valid", 32'(bus0.instr_valid_o), 32'd0);

        // Redirect with two responses outstanding
        ack_pct = 100; rv_pct = 0; rdy_pct = 100;
        repeat (3) step();
        chk("redir_outstanding", 32'(pending.size()), 32'd2);
        redir_req = 1'b1; redir_target = 32'h0000_0100;
        step();
        step();
        chk("drain_req_low", 32'(bus0.imem_req_o), 32'd0);
        rv_pct = 100;
        repeat (8) step();

        // Unaligned redirect target
        redir_req = 1'b1; redir_target = 32'h0000_0103;
        repeat (10) step();

        // Randomized traffic with occasional redirects
        for (int blk = 0; blk < 6; blk++) begin
            ack_pct = $urandom_range(40, 100);
            rv_pct  = $urandom_range(30, 100);
            rdy_pct = $urandom_range(20, 100);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(24) == 0) begin
                    redir_req = 1'b1;
                    redir_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                            : $urandom();
                end
                step();
            end
        end

        // Reset mid-transaction
        ack_pct = 100; rv_pct = 100; rdy_pct = 0;
        repeat (3) step();
        rv_pct = 0;
        repeat (3) step();
        #3;
        mon_en = 1'b0;
        rst = 1'b0;
        drive_idle();
        #1;
        chk("midrst_req", 32'(bus0.imem_req_o), 32'd0);
        chk("midrst_valid", 32'(bus0.instr_valid_o), 32'd0);
        chk("midrst_addr", bus0.imem_addr_o, 32'h0);
        chk("midrst_instr", bus0.instr_o, 32'h0);
        chk("midrst_instr_pc", bus0.instr_pc_o, 32'h0);
        pending.delete();
        exp_q.delete();
        cur_valid = 1'b0;
        after_redirect = 1'b0;
        exp_fetch_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        ack_pct = 100; rv_pct = 100; rdy_pct = 100;
        repeat (20) step();

        // Quiesce and confirm everything expected was delivered
        ack_pct = 0; rv_pct = 100; rdy_pct = 100;
        for (int i = 0; i < 100; i++) begin
            if (pending.size() == 0 && exp_q.size() == 0) break;
            step();
        end
        step();
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(bus0.instr_valid_o), 32'd0);

        for (int i = 0; i < 200 && !wrap_done; i++) @(negedge clk);
        chk("wrap_test_done", 32'(wrap_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
